mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Parametrised successor to the fixed-width MAR/MDR/byte-split path of the LC-3b multicycle datapath.
- Owns the memory address and data registers, byte-lane selection and the memory handshake, so the datapath issues one request and receives one response.
- Generalised to any power-of-two data width with N byte lanes.
- Adds a request/response handshake and a measured-latency counter.

Parameters:
- DATA_WIDTH, 16, memory word width in bits; power of two, at least 16.
- ADDR_WIDTH, 16, byte address width.
- LAT_WIDTH, 8, width of the saturating latency counter.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  core request strobe.
- req_ready  out  1  unit can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_byte  in  1  1 = byte access, 0 = word access.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data; for byte stores, bits [7:0] are used.
- resp_valid  out  1  one-cycle pulse: access complete.
- resp_rdata  out  DATA_WIDTH  load result; byte loads are zero-extended.
- resp_err  out  1  valid with resp_valid; misaligned word access (feature only).
- last_latency  out  LAT_WIDTH  cycles from ACCESS entry to mem_resp for the last completed access.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_byte_enable  out  DATA_WIDTH/8  write lane mask.
- mem_address  out  ADDR_WIDTH  registered address (MAR).
- mem_wdata  out  DATA_WIDTH  registered write data (MDR).
- mem_rdata  in  DATA_WIDTH  memory read data.
- mem_resp  in  1  memory completion.

Behaviour:
- Constants:
  - NB = DATA_WIDTH/8.
  - LB = log2(NB).
  - lane = req_addr[LB-1:0].
- FSM states: IDLE, ACCESS, RESP.
- Reset:
  - State goes to IDLE.
  - Outputs after reset: req_ready = 1; resp_valid, resp_err, mem_read and mem_write = 0; mem_byte_enable = 0.
  - mem_address, mem_wdata, resp_rdata and last_latency = 0.
- IDLE:
  - req_ready = 1.
  - On req_valid, capture the request (the MAR/MDR load) and go to ACCESS on the next cycle.
  - Word access: MAR = req_addr with low LB bits cleared; MDR = req_wdata; mem_byte_enable = all ones.
  - Byte access: MAR = req_addr with low LB bits cleared; MDR = req_wdata[7:0] replicated to every lane; mem_byte_enable = one-hot at lane.
  - The lane index is stored internally.
- ACCESS:
  - req_ready = 0.
  - mem_read = !write and mem_write = write, held steady until mem_resp.
  - The latency counter starts at 1 on entry and increments each cycle, saturating at all ones.
  - On mem_resp, go to RESP, register the load data and copy the counter to last_latency.
  - Load data: word access takes mem_rdata; byte access takes mem_rdata[8*lane +: 8] zero-extended.
  - Stores leave resp_rdata unchanged.
- RESP:
  - resp_valid = 1 for exactly one cycle; req_ready = 0.
  - Then return to IDLE.
  - Minimum request-to-request spacing is 3 cycles.
- Request timing:
  - req_valid is ignored when req_ready = 0; the core must hold its request.
  - mem_resp is ignored outside ACCESS.
  - mem_resp asserted in the first ACCESS cycle gives last_latency = 1.
- Reset in ACCESS drops the strobes in the same edge; no resp_valid is generated.
- resp_rdata holds its value between responses.

Optional Feature:
- Macro: MEM_ACCESS_MISALIGN_ERR_EN.
- Defined:
  - A word request with lane != 0 skips ACCESS: IDLE → RESP.
  - resp_err = 1, no memory strobe, last_latency unchanged.
- Undefined:
  - The low bits are silently cleared (LC-3b semantics).
  - resp_err is tied to 0.

Decomposition:
- Shared package lc3b_types gains:
  - enum mem_access_state_t {IDLE, ACCESS, RESP};
  - typedef lc3b_mem_lanes as the byte-enable vector for the default width.
- Sub-module lane_select:
  - Combinational extraction of byte `lane` from a word, zero-extended, parametrised by DATA_WIDTH.
  - Replaces the old two-way byte split mux.

Test Plan:
- Word load, addr 0x3004, memory returns 0xBEEF after 3 cycles → mem_read high for 3 cycles, mem_address 0x3004, resp_rdata 0xBEEF, last_latency 3, resp_valid one cycle.
- Byte load, addr 0x3005, mem_rdata 0xA55A → mem_address 0x3004, resp_rdata 0x00A5.
- Byte store, addr 0x2001, wdata 0x1234, DATA_WIDTH 16 → mem_wdata 0x3434, mem_byte_enable 2'b10, mem_write until mem_resp.
- DATA_WIDTH 32, byte load at addr 0x0003, mem_rdata 0x11223344 → mem_address 0x0000, resp_rdata 0x00000011.
- Misaligned word store, addr 0x0003:
  - Macro on: resp_err 1, no mem_write, 2 cycles to resp_valid.
  - Macro off: mem_address 0x0002, resp_err 0.
- Reset asserted in the 2nd ACCESS cycle → next cycle IDLE, mem_read 0, no resp_valid; mem_resp held 1 for 300 cycles on a new access → last_latency saturates at 255.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types: memory access FSM states and
// the byte-lane mask for the default 16-bit memory word.
package lc3b_types;

  localparam int LC3B_DATA_WIDTH = 16;
  localparam int LC3B_LANES      = LC3B_DATA_WIDTH / 8;

  typedef logic [LC3B_LANES-1:0] lc3b_mem_lanes;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } mem_access_state_t;

endpackage

// File: rtl/lane_select.sv
// Extracts one byte lane from a memory word, zero-extended
// back to the full word width.
module lane_select #(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0]              word_i,
  input  logic [$clog2(DATA_WIDTH/8)-1:0]    lane_i,
  output logic [DATA_WIDTH-1:0]              byte_o
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int LB = $clog2(NB);

  logic [7:0] sel;

  always_comb begin
    sel = '0;
    for (int i = 0; i < NB; i++) begin
      if (lane_i == LB'(i)) sel = word_i[8*i +: 8];
    end
  end

  assign byte_o = {{(DATA_WIDTH-8){1'b0}}, sel};

endmodule

// File: rtl/mem_access_unit.sv
// MAR/MDR, byte-lane steering and memory handshake for the core.
// MEM_ACCESS_MISALIGN_ERR_EN: flag misaligned word accesses.
module mem_access_unit
  import lc3b_types::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int LAT_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic                    req_byte,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err,
  output logic [LAT_WIDTH-1:0]    last_latency,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [DATA_WIDTH/8-1:0] mem_byte_enable,
  output logic [ADDR_WIDTH-1:0]   mem_address,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_resp
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int LB = $clog2(NB);

  mem_access_state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] mar_q;
  logic [DATA_WIDTH-1:0] mdr_q;
  logic [NB-1:0]         be_q;
  logic [LB-1:0]         lane_q;
  logic                  write_q;
  logic                  byte_q;
  logic [LAT_WIDTH-1:0]  cnt_q;
  logic [LAT_WIDTH-1:0]  lat_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [LB-1:0]         lane;
  logic [NB-1:0]         lane_oh;
  logic [DATA_WIDTH-1:0] byte_rdata;
  logic                  accept;
  logic                  skip;

  assign lane    = req_addr[LB-1:0];
  assign lane_oh = NB'(1) << lane;
  assign accept  = (state_q == IDLE) && req_valid;

  lane_select #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lane_select (
    .word_i (mem_rdata),
    .lane_i (lane_q),
    .byte_o (byte_rdata)
  );

`ifdef MEM_ACCESS_MISALIGN_ERR_EN
  logic err_q;

  // Misaligned words never reach memory; they answer with an error.
  assign skip     = !req_byte && (lane != '0);
  assign resp_err = resp_valid && err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= skip;
    end
  end
`else
  assign skip     = 1'b0;
  assign resp_err = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = skip ? RESP : ACCESS;
      end
      ACCESS: begin
        mem_read  = !write_q;
        mem_write = write_q;
        if (mem_resp) state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
      be_q    <= '0;
      lane_q  <= '0;
      write_q <= 1'b0;
      byte_q  <= 1'b0;
      cnt_q   <= '0;
      lat_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        mar_q   <= {req_addr[ADDR_WIDTH-1:LB], {LB{1'b0}}};
        mdr_q   <= req_byte ? {NB{req_wdata[7:0]}} : req_wdata;
        be_q    <= req_byte ? lane_oh : '1;
        lane_q  <= lane;
        write_q <= req_write;
        byte_q  <= req_byte;
        cnt_q   <= LAT_WIDTH'(1);
      end
      if (state_q == ACCESS) begin
        if (mem_resp) begin
          lat_q <= cnt_q;
          if (!write_q) rdata_q <= byte_q ? byte_rdata : mem_rdata;
        end else if (!(&cnt_q)) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign mem_address     = mar_q;
  assign mem_wdata       = mdr_q;
  assign mem_byte_enable = be_q;
  assign resp_rdata      = rdata_q;
  assign last_latency    = lat_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed table, corner sequences
// and a random load/store run against a byte-array memory model.
module tb_mem_access_unit;

`ifdef MEM_ACCESS_MISALIGN_ERR_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid, req_write, req_byte;
  logic [15:0] req_addr, req_wdata, mem_rdata;
  logic        mem_resp;
  logic        req_ready, resp_valid, resp_err;
  logic        mem_read, mem_write;
  logic [15:0] resp_rdata, mem_address, mem_wdata;
  logic [7:0]  last_latency;
  logic [1:0]  mem_byte_enable;

  logic        req_valid_w, req_write_w, req_byte_w;
  logic [15:0] req_addr_w;
  logic [31:0] req_wdata_w, mem_rdata_w;
  logic        mem_resp_w;
  logic        req_ready_w, resp_valid_w, resp_err_w;
  logic        mem_read_w, mem_write_w;
  logic [31:0] resp_rdata_w, mem_wdata_w;
  logic [15:0] mem_address_w;
  logic [7:0]  last_latency_w;
  logic [3:0]  mem_byte_enable_w;

  mem_access_unit #(.DATA_WIDTH(16)) u16 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_byte(req_byte),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .last_latency(last_latency),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  mem_access_unit #(.DATA_WIDTH(32)) u32 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_w), .req_ready(req_ready_w),
    .req_write(req_write_w), .req_byte(req_byte_w),
    .req_addr(req_addr_w), .req_wdata(req_wdata_w),
    .resp_valid(resp_valid_w), .resp_rdata(resp_rdata_w),
    .resp_err(resp_err_w), .last_latency(last_latency_w),
    .mem_read(mem_read_w), .mem_write(mem_write_w),
    .mem_byte_enable(mem_byte_enable_w),
    .mem_address(mem_address_w), .mem_wdata(mem_wdata_w),
    .mem_rdata(mem_rdata_w), .mem_resp(mem_resp_w)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Environment memory for the 16-bit unit: 256 words.
  logic [15:0] bmem [0:255];

  typedef struct {
    logic        ready;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    int          rdc;
    int          wrc;
    int          resp_at;
    logic        got;
    logic        stb_in_resp;
    logic [15:0] rdata;
    logic        err;
    logic [7:0]  lat;
    logic        valid_after;
    logic        ready_after;
  } obs_t;

  task automatic access(input logic w, input logic b,
                        input logic [15:0] a, input logic [15:0] wd,
                        input int delay, output obs_t o);
    int cyc;
    @(negedge clk);
    o.ready   = req_ready;
    req_valid = 1'b1;
    req_write = w;
    req_byte  = b;
    req_addr  = a;
    req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = 16'($urandom);
    req_wdata = 16'($urandom);
    o.addr  = mem_address;
    o.wdata = mem_wdata;
    o.be    = mem_byte_enable;
    o.rdc   = 0;
    o.wrc   = 0;
    cyc     = 0;
    while (!resp_valid && cyc < delay + 3) begin
      cyc++;
      if (mem_read) o.rdc++;
      if (mem_write) o.wrc++;
      if (cyc == delay) begin
        mem_resp = 1'b1;
        if (mem_read) mem_rdata = bmem[mem_address[8:1]];
        if (mem_write) begin
          for (int l = 0; l < 2; l++)
            if (mem_byte_enable[l])
              bmem[mem_address[8:1]][8*l +: 8] = mem_wdata[8*l +: 8];
        end
      end
      @(negedge clk);
      mem_resp  = 1'b0;
      mem_rdata = 16'($urandom);
    end
    o.resp_at     = cyc;
    o.got         = resp_valid;
    o.stb_in_resp = mem_read | mem_write;
    o.rdata       = resp_rdata;
    o.err         = resp_err;
    o.lat         = last_latency;
    @(negedge clk);
    o.valid_after = resp_valid;
    o.ready_after = req_ready;
  endtask

  task automatic acc32(input logic w, input logic b,
                       input logic [15:0] a, input logic [31:0] wd,
                       input logic [31:0] rd,
                       output logic [15:0] oa, output logic [31:0] owd,
                       output logic [3:0] obe, output logic ostb,
                       output logic ov, output logic [31:0] ordata);
    @(negedge clk);
    req_valid_w = 1'b1;
    req_write_w = w;
    req_byte_w  = b;
    req_addr_w  = a;
    req_wdata_w = wd;
    @(negedge clk);
    req_valid_w = 1'b0;
    oa   = mem_address_w;
    owd  = mem_wdata_w;
    obe  = mem_byte_enable_w;
    ostb = w ? mem_write_w : mem_read_w;
    mem_resp_w  = 1'b1;
    mem_rdata_w = rd;
    @(negedge clk);
    mem_resp_w = 1'b0;
    ov     = resp_valid_w;
    ordata = resp_rdata_w;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic        w;
    logic        b;
    logic [15:0] addr;
    logic [15:0] wd;
    logic        pre_en;
    logic [15:0] pre;
    int          delay;
    logic [15:0] e_addr;
    logic [15:0] e_wd;
    logic [1:0]  e_be;
    logic [15:0] e_rdata;
    logic [7:0]  e_lat;
    int          e_rdc;
    int          e_wrc;
    logic        e_err;
    logic        skip;
  } vec_t;

  vec_t vt [8];

  // Byte-addressed reference memory for the random phase.
  logic [7:0] rm [0:511];

  initial begin
    obs_t        o;
    logic [15:0] oa;
    logic [31:0] owd, ord;
    logic [3:0]  obe;
    logic        ostb, ov;
    int          seen;

    reset = 1'b1;
    req_valid = 0; req_write = 0; req_byte = 0;
    req_addr = 0; req_wdata = 0; mem_rdata = 0; mem_resp = 0;
    req_valid_w = 0; req_write_w = 0; req_byte_w = 0;
    req_addr_w = 0; req_wdata_w = 0; mem_rdata_w = 0; mem_resp_w = 0;
    for (int i = 0; i < 256; i++) bmem[i] = 16'($urandom);

    vt[0] = '{0,0,16'h3004,16'h0000,1,16'hBEEF,3,16'h3004,16'h0000,
              2'b11,16'hBEEF,8'd3,3,0,0,0};
    vt[1] = '{0,1,16'h3005,16'h0000,1,16'hA55A,1,16'h3004,16'h0000,
              2'b10,16'h00A5,8'd1,1,0,0,0};
    vt[2] = '{1,1,16'h2001,16'h1234,0,16'h0000,2,16'h2000,16'h3434,
              2'b10,16'h00A5,8'd2,0,2,0,0};
    vt[3] = '{0,1,16'h2001,16'hFFFF,0,16'h0000,4,16'h2000,16'hFFFF,
              2'b10,16'h0034,8'd4,4,0,0,0};
    vt[4] = '{1,0,16'h0004,16'hCAFE,0,16'h0000,1,16'h0004,16'hCAFE,
              2'b11,16'h0034,8'd1,0,1,0,0};
    vt[5] = '{0,0,16'h0004,16'h1111,0,16'h0000,2,16'h0004,16'h1111,
              2'b11,16'hCAFE,8'd2,2,0,0,0};
    vt[6] = '{0,1,16'h0004,16'h0000,0,16'h0000,5,16'h0004,16'h0000,
              2'b01,16'h00FE,8'd5,5,0,0,0};
    vt[7] = '{1,0,16'h0003,16'h5555,0,16'h0000,1,16'h0002,16'h5555,
              2'b11,16'h00FE,(MIS ? 8'd5 : 8'd1),0,(MIS ? 0 : 1),
              MIS,MIS};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_valid", resp_valid, 0);
    chk("rst_err", resp_err, 0);
    chk("rst_strobes", {mem_read, mem_write}, 0);
    chk("rst_be", mem_byte_enable, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_lat", last_latency, 0);
    chk("rst_be32", mem_byte_enable_w, 0);

    for (int i = 0; i < 8; i++) begin
      if (vt[i].pre_en) bmem[vt[i].addr[8:1]] = vt[i].pre;
      access(vt[i].w, vt[i].b, vt[i].addr, vt[i].wd, vt[i].delay, o);
      chk($sformatf("v%0d_ready", i), o.ready, 1);
      chk($sformatf("v%0d_addr", i), o.addr, vt[i].e_addr);
      chk($sformatf("v%0d_wdata", i), o.wdata, vt[i].e_wd);
      chk($sformatf("v%0d_be", i), o.be, vt[i].e_be);
      chk($sformatf("v%0d_rdc", i), o.rdc, vt[i].e_rdc);
      chk($sformatf("v%0d_wrc", i), o.wrc, vt[i].e_wrc);
      chk($sformatf("v%0d_got", i), o.got, 1);
      chk($sformatf("v%0d_resp_at", i), o.resp_at,
          vt[i].skip ? 0 : vt[i].delay);
      chk($sformatf("v%0d_stb_resp", i), o.stb_in_resp, 0);
      chk($sformatf("v%0d_rdata", i), o.rdata, vt[i].e_rdata);
      chk($sformatf("v%0d_err", i), o.err, vt[i].e_err);
      chk($sformatf("v%0d_lat", i), o.lat, vt[i].e_lat);
      chk($sformatf("v%0d_pulse", i), o.valid_after, 0);
      chk($sformatf("v%0d_ready_after", i), o.ready_after, 1);
    end

    // Reset during the second ACCESS cycle, then stray mem_resp.
    @(negedge clk);
    req_valid = 1; req_write = 0; req_byte = 0; req_addr = 16'h0010;
    @(negedge clk);
    req_valid = 0;
    chk("ra_read1", mem_read, 1);
    @(negedge clk);
    chk("ra_read2", mem_read, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("ra_read_drop", mem_read, 0);
    chk("ra_ready", req_ready, 1);
    chk("ra_lat", last_latency, 0);
    seen = 0;
    mem_resp = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (resp_valid || !req_ready || mem_read) seen++;
    end
    mem_resp = 1'b0;
    chk("ra_no_resp", seen, 0);

    access(0, 0, 16'h0020, 16'h0000, 300, o);
    chk("sat_got", o.got, 1);
    chk("sat_rdc", o.rdc, 300);
    chk("sat_lat", o.lat, 255);

    // 32-bit data path.
    acc32(0, 1, 16'h0003, 32'h0, 32'h11223344, oa, owd, obe, ostb, ov, ord);
    chk("w32_ld_addr", oa, 16'h0000);
    chk("w32_ld_be", obe, 4'b1000);
    chk("w32_ld_stb", ostb, 1);
    chk("w32_ld_valid", ov, 1);
    chk("w32_ld_rdata", ord, 32'h00000011);
    chk("w32_ld_lat", last_latency_w, 1);
    acc32(1, 1, 16'h0006, 32'h000000AB, 32'h0, oa, owd, obe, ostb, ov, ord);
    chk("w32_st_addr", oa, 16'h0004);
    chk("w32_st_wdata", owd, 32'hABABABAB);
    chk("w32_st_be", obe, 4'b0100);
    chk("w32_st_stb", ostb, 1);
    chk("w32_st_rdata", ord, 32'h00000011);
    acc32(0, 0, 16'h0008, 32'h0, 32'hDEADBEEF, oa, owd, obe, ostb, ov, ord);
    chk("w32_wd_rdata", ord, 32'hDEADBEEF);
    chk("w32_wd_be", obe, 4'b1111);

    // Random loads/stores against the byte-array model.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      bmem[i]      = 16'($urandom);
      rm[2*i]      = bmem[i][7:0];
      rm[2*i + 1]  = bmem[i][15:8];
    end
    begin
      logic [15:0] m_rdata;
      logic [7:0]  m_lat;
      m_rdata = '0;
      m_lat   = '0;
      for (int n = 0; n < 200; n++) begin
        logic        w, b, mis;
        logic [15:0] a, wd;
        int          al, d;
        w   = 1'($urandom);
        b   = 1'($urandom);
        a   = 16'($urandom_range(0, 511));
        wd  = 16'($urandom);
        d   = int'($urandom_range(1, 5));
        al  = int'(a) & ~1;
        mis = MIS && !b && a[0];
        access(w, b, a, wd, d, o);
        if (!mis) begin
          m_lat = 8'(d);
          if (w && b) rm[a] = wd[7:0];
          else if (w) begin
            rm[al]     = wd[7:0];
            rm[al + 1] = wd[15:8];
          end else if (b) m_rdata = {8'h00, rm[a]};
          else m_rdata = {rm[al + 1], rm[al]};
        end
        chk($sformatf("r%0d_got", n), o.got, 1);
        chk($sformatf("r%0d_rdata", n), o.rdata, m_rdata);
        chk($sformatf("r%0d_err", n), o.err, mis);
        chk($sformatf("r%0d_lat", n), o.lat, m_lat);
        chk($sformatf("r%0d_strobe", n), {o.rdc, o.wrc},
            {(mis || w) ? 0 : d, (mis || !w) ? 0 : d});
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
